// File: rtl/uart_tx_ctrl.sv
// UART transmit serializer fed by a first-word-fall-through TX FIFO, with its own baud-tick generator.
// Define UART_TX_PARITY_EN to add a parity bit (PARITY_ODD selects odd parity).
module uart_tx_ctrl #(
  parameter int DATA_WIDTH = 8,
  parameter int OVERSAMPLE = 16,
  parameter int SB_TICKS   = 16,
  parameter int DVSR_WIDTH = 11
`ifdef UART_TX_PARITY_EN
  ,
  parameter bit PARITY_ODD = 1'b0
`endif
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DVSR_WIDTH-1:0] dvsr,
  input  logic                  fifo_empty,
  input  logic [DATA_WIDTH-1:0] fifo_rd_data,
  output logic                  fifo_rd,
  output logic                  tx,
  output logic                  tx_busy,
  output logic                  tx_done_tick
);

  localparam int SMAX = (SB_TICKS > OVERSAMPLE) ? SB_TICKS : OVERSAMPLE;
  localparam int SW   = (SMAX > 2) ? $clog2(SMAX) : 1;
  localparam int NW   = (DATA_WIDTH > 2) ? $clog2(DATA_WIDTH) : 1;

`ifdef UART_TX_PARITY_EN
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
  typedef enum logic [2:0] {IDLE, START, DATA, STOP} state_t;
`endif

  state_t                state_reg, state_next;
  logic [DVSR_WIDTH-1:0] cnt_reg;
  logic [SW-1:0]         s_reg, s_next;
  logic [NW-1:0]         n_reg, n_next;
  logic [DATA_WIDTH-1:0] shift_reg, shift_next;
  logic                  tx_reg, tx_next;
  logic                  tick;
  logic                  rd_next;
  logic                  done_next;
`ifdef UART_TX_PARITY_EN
  logic                  par_reg;
`endif

  // >= rather than == so a smaller dvsr written mid-count never wraps the counter
  assign tick = (state_reg != IDLE) && (cnt_reg >= dvsr);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
      cnt_reg   <= '0;
      s_reg     <= '0;
      n_reg     <= '0;
      shift_reg <= '0;
      tx_reg    <= 1'b1;
`ifdef UART_TX_PARITY_EN
      par_reg   <= 1'b0;
`endif
    end else begin
      state_reg <= state_next;
      s_reg     <= s_next;
      n_reg     <= n_next;
      shift_reg <= shift_next;
      tx_reg    <= tx_next;
      if (state_reg == IDLE || tick)
        cnt_reg <= '0;
      else
        cnt_reg <= cnt_reg + 1'b1;
`ifdef UART_TX_PARITY_EN
      if (rd_next)
        par_reg <= (^fifo_rd_data) ^ PARITY_ODD;
`endif
    end
  end

  always_comb begin
    state_next = state_reg;
    s_next     = s_reg;
    n_next     = n_reg;
    shift_next = shift_reg;
    rd_next    = 1'b0;
    done_next  = 1'b0;
    case (state_reg)
      IDLE: begin
        if (!fifo_empty) begin
          rd_next    = 1'b1;
          shift_next = fifo_rd_data;
          s_next     = '0;
          n_next     = '0;
          state_next = START;
        end
      end
      START: begin
        if (tick) begin
          if (s_reg == SW'(OVERSAMPLE - 1)) begin
            s_next     = '0;
            state_next = DATA;
          end else begin
            s_next = s_reg + 1'b1;
          end
        end
      end
      DATA: begin
        if (tick) begin
          if (s_reg == SW'(OVERSAMPLE - 1)) begin
            s_next     = '0;
            shift_next = shift_reg >> 1;
            if (n_reg == NW'(DATA_WIDTH - 1)) begin
`ifdef UART_TX_PARITY_EN
              state_next = PARITY;
`else
              state_next = STOP;
`endif
            end else begin
              n_next = n_reg + 1'b1;
            end
          end else begin
            s_next = s_reg + 1'b1;
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      PARITY: begin
        if (tick) begin
          if (s_reg == SW'(OVERSAMPLE - 1)) begin
            s_next     = '0;
            state_next = STOP;
          end else begin
            s_next = s_reg + 1'b1;
          end
        end
      end
`endif
      STOP: begin
        if (tick) begin
          if (s_reg == SW'(SB_TICKS - 1)) begin
            done_next  = 1'b1;
            s_next     = '0;
            state_next = IDLE;
          end else begin
            s_next = s_reg + 1'b1;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // tx is registered from the line level of the state being entered
  always_comb begin
    tx_next = 1'b1;
    case (state_next)
      START:   tx_next = 1'b0;
      DATA:    tx_next = shift_next[0];
`ifdef UART_TX_PARITY_EN
      PARITY:  tx_next = par_reg;
`endif
      default: tx_next = 1'b1;
    endcase
  end

  assign fifo_rd      = rd_next & ~rst;
  assign tx_done_tick = done_next & ~rst;
  assign tx_busy      = (state_reg != IDLE);
  assign tx           = tx_reg;

endmodule

// File: tb/tb_uart_tx_ctrl.sv
// Directed bench for uart_tx_ctrl: small FWFT FIFO model, per-bit line checks, counted comparisons.
// Parity frame is exercised only when UART_TX_PARITY_EN is defined.
module tb_uart_tx_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [10:0] dvsr;
  logic        fifo_empty;
  logic [7:0]  fifo_rd_data;
  logic        fifo_rd;
  logic        tx;
  logic        tx_busy;
  logic        tx_done_tick;

  int total = 0;
  int bad   = 0;

  logic [7:0] fmem [0:7];
  int wp = 0;
  int rp = 0;
  int rd_cycles = 0;

  always #5 clk = ~clk;

  uart_tx_ctrl dut (
    .clk          (clk),
    .rst          (rst),
    .dvsr         (dvsr),
    .fifo_empty   (fifo_empty),
    .fifo_rd_data (fifo_rd_data),
    .fifo_rd      (fifo_rd),
    .tx           (tx),
    .tx_busy      (tx_busy),
    .tx_done_tick (tx_done_tick)
  );

  assign fifo_empty   = (wp == rp);
  assign fifo_rd_data = fmem[rp[2:0]];

  always @(posedge clk) begin
    if (fifo_rd) begin
      rd_cycles <= rd_cycles + 1;
      if (!fifo_empty) rp <= rp + 1;
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [7:0] b);
    fmem[wp[2:0]] = b;
    wp = wp + 1;
  endtask

  // Expected line level per bit slot: start, data LSB first, [parity], stop
  function automatic logic [10:0] make_pat(input logic [7:0] b, input bit par);
    logic [10:0] p;
    p    = '1;
    p[0] = 1'b0;
    for (int i = 0; i < 8; i++) p[1+i] = b[i];
    if (par) p[9] = ^b;
    return p;
  endfunction

  // Entered at the sample right after the start-bit fall; leaves at the first idle sample.
  task automatic frame_check(input string tag, input logic [10:0] pat, input int nb, input int len);
    int done_k;
    int done_n;
    done_k = -1;
    done_n = 0;
    for (int k = 0; k < nb * len; k++) begin
      if ((k % len) == 0 || (k % len) == len - 1)
        check_eq($sformatf("%s_slot%0d_k%0d", tag, k / len, k), {31'd0, tx}, {31'd0, pat[k / len]});
      if (tx_done_tick) begin
        if (done_k < 0) done_k = k;
        done_n++;
      end
      step();
    end
    check_eq({tag, "_done_k"}, done_k, nb * len - 1);
    check_eq({tag, "_done_n"}, done_n, 1);
    check_eq({tag, "_idle_tx"}, {31'd0, tx}, 32'd1);
    check_eq({tag, "_idle_busy"}, {31'd0, tx_busy}, 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int kk;
    rst  = 1'b1;
    dvsr = 11'd3;
    push(8'hA5);

    // reset held with a non-empty FIFO
    for (int i = 0; i < 4; i++) begin
      step();
      check_eq("rst_tx", {31'd0, tx}, 32'd1);
      check_eq("rst_rd", {31'd0, fifo_rd}, 32'd0);
      check_eq("rst_busy", {31'd0, tx_busy}, 32'd0);
    end
    rst = 1'b0;
    #1;
    check_eq("rst_first_pop", {31'd0, fifo_rd}, 32'd1);

    // 0xA5 at dvsr=3: 64 clk per bit
    step();
    check_eq("a5_fall", {31'd0, tx}, 32'd0);
    check_eq("a5_rd_low", {31'd0, fifo_rd}, 32'd0);
    frame_check("a5", make_pat(8'hA5, 1'b0), 10, 64);
    check_eq("a5_rd_width", rd_cycles, 1);
    check_eq("a5_pops", rp, 1);

    // back-to-back 0x00 then 0xFF at dvsr=0
    dvsr = 11'd0;
    push(8'h00);
    push(8'hFF);
    #1;
    check_eq("b2b_pop1", {31'd0, fifo_rd}, 32'd1);
    step();
    check_eq("b2b0_fall", {31'd0, tx}, 32'd0);
    frame_check("b2b0", make_pat(8'h00, 1'b0), 10, 16);
    check_eq("b2b_pop2", {31'd0, fifo_rd}, 32'd1);
    step();
    check_eq("b2b1_fall", {31'd0, tx}, 32'd0);
    frame_check("b2b1", make_pat(8'hFF, 1'b0), 10, 16);
    check_eq("b2b_pops", rp, 3);

    // reset during data bit 3 (bit3 of 0xA5 is 0)
    push(8'hA5);
    push(8'h3C);
    #1;
    step();
    repeat (70) step();
    check_eq("mid_bit3", {31'd0, tx}, 32'd0);
    rst = 1'b1;
    step();
    check_eq("mid_rst_tx", {31'd0, tx}, 32'd1);
    check_eq("mid_rst_busy", {31'd0, tx_busy}, 32'd0);
    check_eq("mid_rst_rd", {31'd0, fifo_rd}, 32'd0);
    step();
    check_eq("mid_rst_rd2", {31'd0, fifo_rd}, 32'd0);
    check_eq("mid_rst_pops", rp, 4);
    rst = 1'b0;
    #1;
    check_eq("mid_repop", {31'd0, fifo_rd}, 32'd1);
    step();
    check_eq("3c_fall", {31'd0, tx}, 32'd0);
    frame_check("3c", make_pat(8'h3C, 1'b0), 10, 16);
    check_eq("3c_pops", rp, 5);

    // dvsr 100 -> 2 at cnt=50 in the start bit, byte 0x01
    dvsr = 11'd100;
    push(8'h01);
    #1;
    step();
    check_eq("dv_fall", {31'd0, tx}, 32'd0);
    repeat (50) step();
    dvsr = 11'd2;
    for (int k = 51; k <= 144; k++) begin
      step();
      if (k == 95)  check_eq("dv_k95",  {31'd0, tx}, 32'd0);
      if (k == 96)  check_eq("dv_k96",  {31'd0, tx}, 32'd1);
      if (k == 143) check_eq("dv_k143", {31'd0, tx}, 32'd1);
      if (k == 144) check_eq("dv_k144", {31'd0, tx}, 32'd0);
    end
    kk = 144;
    while (tx_busy && kk < 2000) begin
      step();
      kk++;
    end
    check_eq("dv_end_k", kk, 528);

`ifdef UART_TX_PARITY_EN
    // even parity over 0x07 is 1; 11 slots of 64 clk
    dvsr = 11'd3;
    push(8'h07);
    #1;
    step();
    check_eq("par_fall", {31'd0, tx}, 32'd0);
    frame_check("par", make_pat(8'h07, 1'b1), 11, 64);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
